// File: rtl/imemspx_req_pkg.sv
// Shared types, parameter defaults and the credit-width helper for imemspx_req.
package imemspx_req_pkg;

    localparam int ADDRBIT_DEF   = 11;
    localparam int DEPTH_DEF     = 1536;
    localparam int WIDTH_DEF     = 32;
    localparam int RD_LAT_DEF    = 3;
    localparam int RSP_DEPTH_DEF = 4;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef struct packed {
        logic vld;
        logic oor;
    } rd_ent_t;

    // Credits count from 0 up to RSP_DEPTH inclusive.
    function automatic int credWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int CRED_W_DEF = credWidth(RSP_DEPTH_DEF);

endpackage

// File: rtl/imemspx_req_fifo.sv
// Response FIFO for imemspx_req: registered storage whose head entry drives rdata_o,
// so a word pushed in one cycle is visible at the output the next cycle.
module imemspx_req_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Push and pop may coincide even when full: the head word is consumed before the edge.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                store_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q          <= ptrInc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptrInc(rd_ptr_q);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + 1'b1;
            end else if (pop_i && !push_i) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign rdata_o = store_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/imemspx_req.sv
// Requester-side sequencer for a wrapped single-port RAM with credit-based read responses.
// Optional power-up clear of the whole RAM is enabled by defining IMEMSPX_REQ_INIT_EN.
module imemspx_req
    import imemspx_req_pkg::*;
#(
    parameter int ADDRBIT   = ADDRBIT_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               req_vld,
    output logic               req_rdy,
    input  logic               req_we,
    input  logic [ADDRBIT-1:0] req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               rsp_vld,
    input  logic               rsp_rdy,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic [ADDRBIT-1:0] mem_a,
    output logic               mem_we,
    output logic               mem_re,
    output logic [WIDTH-1:0]   mem_di,
    input  logic [WIDTH-1:0]   mem_do,
    output logic               err_oor,
    output logic               init_done
);
    localparam int CRED_W = credWidth(RSP_DEPTH);
    localparam logic [CRED_W-1:0]  CRED_FULL = CRED_W'(RSP_DEPTH);
    localparam logic [ADDRBIT:0]   DEPTH_W   = (ADDRBIT + 1)'(DEPTH);
    localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);

    state_t             state_q;
    logic [ADDRBIT-1:0] init_cnt_q;
    logic               init_done_q;
    logic [ADDRBIT-1:0] mem_a_q;
    logic               mem_we_q;
    logic               mem_re_q;
    logic [WIDTH-1:0]   mem_di_q;
    logic               err_oor_q;
    rd_ent_t            iss_q;
    rd_ent_t            rd_pipe_q [1:RD_LAT];
    logic [CRED_W-1:0]  credits_q;
    logic [CRED_W-1:0]  credits_d;

    logic             addr_oor;
    logic             accept;
    logic             acc_rd;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic             fifo_full;
    logic             fifo_empty;

    assign addr_oor = ({1'b0, req_addr} >= DEPTH_W);
    assign req_rdy  = init_done_q & ((credits_q != '0) | req_we);
    assign accept   = req_vld & req_rdy;
    assign acc_rd   = accept & ~req_we;

    // INIT sweeps zeros over the RAM; RUN registers one accepted request per cycle onto mem_*.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
`ifdef IMEMSPX_REQ_INIT_EN
            state_q <= INIT;
`else
            state_q <= RUN;
`endif
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            mem_a_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_di_q    <= '0;
            err_oor_q   <= 1'b0;
            iss_q       <= '0;
        end else begin
            init_done_q <= (state_q == RUN);
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            iss_q       <= '0;
            case (state_q)
                INIT: begin
                    mem_we_q <= 1'b1;
                    mem_a_q  <= init_cnt_q;
                    mem_di_q <= '0;
                    if (init_cnt_q == LAST_ADDR) begin
                        state_q <= RUN;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        mem_a_q   <= req_addr;
                        mem_di_q  <= req_wdata;
                        mem_we_q  <= req_we & ~addr_oor;
                        mem_re_q  <= ~req_we & ~addr_oor;
                        iss_q.vld <= ~req_we;
                        iss_q.oor <= addr_oor;
                        if (addr_oor) begin
                            err_oor_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Out-of-range reads still travel the pipe so their zero response keeps request order.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 1; i <= RD_LAT; i++) begin
                rd_pipe_q[i] <= '0;
            end
        end else begin
            rd_pipe_q[1] <= iss_q;
            for (int i = 2; i <= RD_LAT; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
        end
    end

    assign push      = rd_pipe_q[RD_LAT].vld;
    assign push_data = rd_pipe_q[RD_LAT].oor ? '0 : mem_do;
    assign pop       = rsp_vld & rsp_rdy;

    always_comb begin
        credits_d = credits_q;
        if (acc_rd && !pop) begin
            credits_d = credits_q - 1'b1;
        end else if (pop && !acc_rd) begin
            credits_d = credits_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            credits_q <= CRED_FULL;
        end else begin
            credits_q <= credits_d;
        end
    end

    imemspx_req_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_    (rst_),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (rsp_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A push into a full FIFO without a matching pop means the credit accounting is broken.
    assert property (@(posedge clk) disable iff (!rst_) !(push && fifo_full && !pop));

    assign rsp_vld   = ~fifo_empty;
    assign mem_a     = mem_a_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_di    = mem_di_q;
    assign err_oor   = err_oor_q;
    assign init_done = init_done_q;

endmodule
